// File: rtl/md5_block_sched.sv
// md5_block_sched: packs an ASCII byte stream into 512-bit MD5 blocks, applies
// MD5 padding and the bit-length trailer, launches the compression core once per
// block and accumulates the chaining words into the final digest.
module md5_block_sched #(
   parameter int          CNT_W = 61,
   parameter logic [31:0] IV_A  = 32'h67452301,
   parameter logic [31:0] IV_B  = 32'hEFCDAB89,
   parameter logic [31:0] IV_C  = 32'h98BADCFE,
   parameter logic [31:0] IV_D  = 32'h10325476
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         blk_start,
   output logic [511:0] blk_data,
   output logic [31:0]  chain_a,
   output logic [31:0]  chain_b,
   output logic [31:0]  chain_c,
   output logic [31:0]  chain_d,
   input  logic         core_done,
   input  logic [31:0]  core_a,
   input  logic [31:0]  core_b,
   input  logic [31:0]  core_c,
   input  logic [31:0]  core_d,
   output logic         busy,
   output logic [127:0] digest,
   output logic         digest_valid
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_LENBLK, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [511:0]     blk_q, blk_d;
   logic [31:0]      ha_q, ha_d, hb_q, hb_d, hc_q, hc_d, hd_q, hd_d;
   logic             pad_pend_q, pad_pend_d;
   logic             len_pend_q, len_pend_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             dv_q, dv_d;
   logic             start_q, start_d;

   logic             xfer;
   logic [5:0]       wr_idx;
   logic [6:0]       n_after;
   logic [CNT_W-1:0] cnt_new;

   // Message length in bits, zero-extended to the 64-bit MD5 trailer.
   function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] cnt);
      logic [63:0] l;
      l = '0;
      l[CNT_W+2:3] = cnt;
      return l;
   endfunction

   assign in_ready = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_DONE);
   assign xfer     = in_valid && in_ready;
   // A byte accepted outside FILL opens a new message at index 0 with count 1.
   assign wr_idx   = (state_q == S_FILL) ? idx_q : 6'd0;
   assign n_after  = {1'b0, wr_idx} + 7'd1;
   assign cnt_new  = (state_q == S_FILL) ? cnt_q + CNT_W'(1) : CNT_W'(1);

   // Next-state logic: byte packing, padding decisions and core handshake.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      blk_d      = blk_q;
      ha_d       = ha_q;
      hb_d       = hb_q;
      hc_d       = hc_q;
      hd_d       = hd_q;
      pad_pend_d = pad_pend_q;
      len_pend_d = len_pend_q;
      last_d     = last_q;
      busy_d     = busy_q;
      dv_d       = dv_q;
      start_d    = 1'b0;

      if (xfer) begin
         if (state_q != S_FILL) begin
            ha_d       = IV_A;
            hb_d       = IV_B;
            hc_d       = IV_C;
            hd_d       = IV_D;
            dv_d       = 1'b0;
            busy_d     = 1'b1;
            blk_d      = '0;
            pad_pend_d = 1'b0;
            len_pend_d = 1'b0;
         end
         blk_d[{wr_idx, 3'b000} +: 8] = in_data;
         idx_d   = n_after[5:0];
         cnt_d   = cnt_new;
         last_d  = in_last;
         state_d = S_FILL;
         if (in_last) begin
            state_d = S_RUN;
            start_d = 1'b1;
            if (n_after <= 7'd55) begin
               blk_d[{n_after[5:0], 3'b000} +: 8] = 8'h80;
               blk_d[511:448] = bit_len(cnt_new);
            end else if (n_after <= 7'd63) begin
               // Pad byte fits, the length trailer spills into an extra block.
               blk_d[{n_after[5:0], 3'b000} +: 8] = 8'h80;
               len_pend_d = 1'b1;
            end else begin
               pad_pend_d = 1'b1;
               len_pend_d = 1'b1;
            end
         end else if (n_after == 7'd64) begin
            state_d = S_RUN;
            start_d = 1'b1;
         end
      end

      case (state_q)
         S_RUN: begin
            if (core_done) begin
               ha_d  = ha_q + core_a;
               hb_d  = hb_q + core_b;
               hc_d  = hc_q + core_c;
               hd_d  = hd_q + core_d;
               blk_d = '0;
               if (len_pend_q) begin
                  state_d = S_LENBLK;
               end else if (last_q) begin
                  state_d = S_DONE;
                  dv_d    = 1'b1;
                  busy_d  = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  state_d = S_FILL;
                  idx_d   = 6'd0;
               end
            end
         end
         S_LENBLK: begin
            if (pad_pend_q) begin
               blk_d[7:0] = 8'h80;
            end
            blk_d[511:448] = bit_len(cnt_q);
            pad_pend_d     = 1'b0;
            len_pend_d     = 1'b0;
            state_d        = S_RUN;
            start_d        = 1'b1;
         end
         default: ;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         blk_q      <= '0;
         ha_q       <= IV_A;
         hb_q       <= IV_B;
         hc_q       <= IV_C;
         hd_q       <= IV_D;
         pad_pend_q <= 1'b0;
         len_pend_q <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         dv_q       <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         blk_q      <= blk_d;
         ha_q       <= ha_d;
         hb_q       <= hb_d;
         hc_q       <= hc_d;
         hd_q       <= hd_d;
         pad_pend_q <= pad_pend_d;
         len_pend_q <= len_pend_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         dv_q       <= dv_d;
         start_q    <= start_d;
      end
   end

   assign blk_start    = start_q;
   assign blk_data     = blk_q;
   assign chain_a      = ha_q;
   assign chain_b      = hb_q;
   assign chain_c      = hc_q;
   assign chain_d      = hd_q;
   assign busy         = busy_q;
   assign digest       = {ha_q, hb_q, hc_q, hd_q};
   assign digest_valid = dv_q;

endmodule
